// File: rtl/lsu_unit_if.sv
// Handshake and bus bundle linking the EXU request port, the LSU and the memory port.
// The slave modport is the LSU's view; master is the surrounding environment's view.
interface lsu_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned RIDX = 5;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic              in_wen;
  logic              in_ren;
  logic [2:0]        in_funct3;
  logic [RIDX-1:0]   in_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic              mem_ren;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NBYTES-1:0] mem_wmask;
  logic [NBYTES-1:0] mem_rmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp_err;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rdata;
  logic [RIDX-1:0]   out_rd;
  logic              out_rd_wen;
  logic              out_err;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_wen, in_ren, in_funct3, in_rd,
    output in_ready,
    output mem_req_valid, mem_wen, mem_ren, mem_addr, mem_wdata, mem_wmask, mem_rmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    output out_valid, out_rdata, out_rd, out_rd_wen, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_wen, in_ren, in_funct3, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_wen, mem_ren, mem_addr, mem_wdata, mem_wmask, mem_rmask,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    input  out_valid, out_rdata, out_rd, out_rd_wen, out_err,
    output out_ready
  );
endinterface

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit: aligns the address, builds byte masks and
// replicated store data, and extracts/extends the load lane from the memory response.
module lsu_unit (
  input  logic      clock,
  input  logic      reset,
  lsu_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned RIDX = 5;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              load_q, load_d;

  logic              in_ready_q, in_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_wen_q, mem_wen_d;
  logic              mem_ren_q, mem_ren_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NBYTES-1:0] mem_wmask_q, mem_wmask_d;
  logic [NBYTES-1:0] mem_rmask_q, mem_rmask_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_rdata_q, out_rdata_d;
  logic [RIDX-1:0]   out_rd_q, out_rd_d;
  logic              out_rd_wen_q, out_rd_wen_d;
  logic              out_err_q, out_err_d;

  size_e             acc_sz;
  logic [1:0]        acc_lane;
  logic              acc_store, acc_load, acc_mis;
  logic [NBYTES-1:0] acc_mask;
  logic [XLEN-1:0]   acc_wdata;
  logic [XLEN-1:0]   rshift, ld_data;

  // Unused funct3 encodings fall through to word size.
  function automatic size_e size_of(input logic [2:0] f3);
    size_e sz;
    unique case (f3)
      3'b000, 3'b100: sz = SZ_B;
      3'b001, 3'b101: sz = SZ_H;
      default:        sz = SZ_W;
    endcase
    return sz;
  endfunction

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    funct3_d      = funct3_q;
    load_d        = load_q;
    mem_wen_d     = mem_wen_q;
    mem_ren_d     = mem_ren_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    mem_rmask_d   = mem_rmask_q;
    out_rdata_d   = out_rdata_q;
    out_rd_d      = out_rd_q;
    out_rd_wen_d  = out_rd_wen_q;
    out_err_d     = out_err_q;

    // Request decode; wen wins when both wen and ren are set.
    acc_sz    = size_of(bus.in_funct3);
    acc_lane  = bus.in_addr[1:0];
    acc_store = bus.in_wen;
    acc_load  = bus.in_ren & ~bus.in_wen;
    unique case (acc_sz)
      SZ_B: begin
        acc_mis   = 1'b0;
        acc_mask  = NBYTES'(4'b0001) << acc_lane;
        acc_wdata = {4{bus.in_wdata[7:0]}};
      end
      SZ_H: begin
        acc_mis   = acc_lane[0];
        acc_mask  = NBYTES'(4'b0011) << acc_lane;
        acc_wdata = {2{bus.in_wdata[15:0]}};
      end
      default: begin
        acc_mis   = |acc_lane;
        acc_mask  = '1;
        acc_wdata = bus.in_wdata;
      end
    endcase

    // Load lane extraction; funct3[2] selects zero extension.
    rshift = bus.mem_rdata >> {lane_q, 3'b000};
    unique case (size_of(funct3_q))
      SZ_B:    ld_data = {{24{rshift[7] & ~funct3_q[2]}}, rshift[7:0]};
      SZ_H:    ld_data = {{16{rshift[15] & ~funct3_q[2]}}, rshift[15:0]};
      default: ld_data = rshift;
    endcase

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          lane_d   = acc_lane;
          funct3_d = bus.in_funct3;
          load_d   = acc_load;
          out_rd_d = bus.in_rd;
          if (!acc_store && !acc_load) begin
            state_d      = RESP;
            out_rdata_d  = '0;
            out_err_d    = 1'b0;
            out_rd_wen_d = 1'b0;
          end else if (acc_mis) begin
            state_d      = RESP;
            out_rdata_d  = '0;
            out_err_d    = 1'b1;
            out_rd_wen_d = 1'b0;
          end else begin
            state_d     = REQ;
            mem_addr_d  = {bus.in_addr[XLEN-1:2], 2'b00};
            mem_wen_d   = acc_store;
            mem_ren_d   = acc_load;
            mem_wmask_d = acc_store ? acc_mask : '0;
            mem_rmask_d = acc_load ? acc_mask : '0;
            mem_wdata_d = acc_store ? acc_wdata : '0;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d      = RESP;
          out_err_d    = bus.mem_resp_err;
          out_rd_wen_d = load_q & ~bus.mem_resp_err;
          out_rdata_d  = load_q ? ld_data : '0;
        end
      end
      RESP: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d      = (state_d == IDLE);
    mem_req_valid_d = (state_d == REQ);
    out_valid_d     = (state_d == RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      lane_q          <= '0;
      funct3_q        <= '0;
      load_q          <= 1'b0;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_wen_q       <= 1'b0;
      mem_ren_q       <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      mem_rmask_q     <= '0;
      out_valid_q     <= 1'b0;
      out_rdata_q     <= '0;
      out_rd_q        <= '0;
      out_rd_wen_q    <= 1'b0;
      out_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      lane_q          <= lane_d;
      funct3_q        <= funct3_d;
      load_q          <= load_d;
      in_ready_q      <= in_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_wen_q       <= mem_wen_d;
      mem_ren_q       <= mem_ren_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      mem_rmask_q     <= mem_rmask_d;
      out_valid_q     <= out_valid_d;
      out_rdata_q     <= out_rdata_d;
      out_rd_q        <= out_rd_d;
      out_rd_wen_q    <= out_rd_wen_d;
      out_err_q       <= out_err_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_ren       = mem_ren_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
  assign bus.mem_rmask     = mem_rmask_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_rd_wen    = out_rd_wen_q;
  assign bus.out_err       = out_err_q;
endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  EXU request valid.
REQ-004 in_ready  output  1  request accepted when in_valid & in_ready.
REQ-005 in_addr  input  32  effective byte address.
REQ-006 in_wdata  input  32  store data, right-aligned.
REQ-007 in_wen / in_ren  input  1 each  store / load request; both 0 means no memory op; both 1 is illegal and is treated as a store.
REQ-008 in_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 in_rd  input  5  destination register index.
REQ-010 mem_req_valid  output  1  request to the AXI interface; mem_req_ready (input, 1) completes it.
REQ-011 mem_wen, mem_ren  output  1 each; mem_addr  output  32; mem_wdata  output  32; mem_wmask, mem_rmask  output  4.
REQ-012 mem_resp_valid  input  1; mem_rdata  input  32; mem_resp_err  input  1 (nonzero bresp/rresp).
REQ-013 out_valid  output  1; out_ready  input  1; out_rdata  output  32; out_rd  output  5; out_rd_wen  output  1; out_err  output  1.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, RESP.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 On accept, the block SHALL register addr, wdata, wen, ren, funct3 and rd; the inputs are not used afterwards.
REQ-017 Misaligned accesses SHALL skip the bus and go IDLE->RESP with out_err=1 and out_rd_wen=0. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-018 A request with wen=ren=0 SHALL go IDLE->RESP with out_rdata=0, out_err=0, out_rd_wen=0.
REQ-019 Otherwise IDLE->REQ; mem_req_valid SHALL be 1 only in REQ, with mem_addr/mask/data stable until mem_req_ready.
REQ-020 REQ->WAIT SHALL occur on mem_req_valid & mem_req_ready.
REQ-021 mem_resp_valid SHALL be sampled only in WAIT; when it is seen, the block SHALL capture data/err and go WAIT->RESP.
REQ-022 mem_addr SHALL equal the registered address with bits [1:0] cleared.
REQ-023 Masks SHALL be B 0001<<a, H 0011<<a, W 1111, where a = addr[1:0].
REQ-024 mem_wdata SHALL be the store data replicated per size: B {4{b}}, H {2{h}}, W as is.
REQ-025 mem_wmask SHALL be 0 for loads; mem_rmask SHALL be 0 for stores.
REQ-026 Load data SHALL be extracted from byte lane a and sign-extended for B/H or zero-extended for BU/HU.
REQ-027 On a load, out_rd_wen SHALL be !mem_resp_err; on a store, it SHALL be 0.
REQ-028 out_err SHALL equal the captured mem_resp_err.
REQ-029 In RESP, out_valid=1 and all out_* SHALL hold until out_ready; RESP->IDLE on handshake.
REQ-030 Best-case latency SHALL be: accept at cycle N, mem_req_valid at N+1, and out_valid one cycle after the response is sampled. Throughput is one request outstanding.
REQ-031 Unused funct3 codes SHALL behave as W.

Reset
REQ-032 On reset, the state SHALL be IDLE, with in_ready=1 and mem_req_valid=out_valid=out_rd_wen=out_err=0.
REQ-033 On reset, all other outputs SHALL be 0.
REQ-034 Reset in any state, including mid-handshake, SHALL return to IDLE next cycle. Any pending memory response is discarded; the memory side is reset together with this block.

Verification
REQ-035 SB, addr 0x8000_0003, wdata 0x0000_00AB -> mem_addr 0x8000_0000, wmask 1000, wdata 0xABABABAB, one mem_req handshake, out_rd_wen=0.
REQ-036 LH, addr 0x8000_0002, rdata 0x8765_1234 -> rmask 1100, out_rdata 0xFFFF8765. LHU at the same address -> 0x00008765.
REQ-037 LW, addr 0x8000_0001 -> no mem_req_valid, out_valid with out_err=1, out_rd_wen=0.
REQ-038 LW with mem_req_ready held low 5 cycles, then out_ready held low 3 cycles -> mem_* and out_* stable throughout, and in_ready=0 until the out handshake.
REQ-039 Load with mem_resp_err=1 -> out_err=1, out_rd_wen=0. A stray mem_resp_valid while in REQ is ignored.
REQ-040 Reset asserted in WAIT -> next cycle IDLE with in_ready=1 and out_valid=0; the following LBU at 0x8000_0001 with rdata 0x0000_F000 returns 0x000000F0.
